// File: rtl/conversao_bcd_binario_if.sv
// Handshake and operand bundle between digit-entry logic and the BCD-to-binary converter.
interface conversao_bcd_binario_if;
  logic       START;
  logic [3:0] C;
  logic [3:0] D;
  logic [3:0] U;
  logic [9:0] NUM;
  logic       BUSY;
  logic       DONE;
  logic       ERRO;

  modport master (output START, C, D, U, input NUM, BUSY, DONE, ERRO);
  modport slave  (input START, C, D, U, output NUM, BUSY, DONE, ERRO);
endinterface

// File: rtl/conversao_bcd_binario.sv
// Three-digit BCD to 10-bit binary converter using reverse double-dabble,
// one bit per clock, sequenced by a START/DONE handshake.
module conversao_bcd_binario (
  input logic                    CLK,
  input logic                    RST,
  conversao_bcd_binario_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [11:0] bcd_q, bcd_d;
  logic [9:0]  bin_q, bin_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  num_q, num_d;
  logic        done_q, done_d;
  logic        erro_q, erro_d;
  logic [21:0] step_w;

  // One reverse double-dabble step on {bcd,bin}: shift right, then any BCD
  // nibble that now reads 8 or more (MSB set) is corrected by -3.
  function automatic logic [21:0] dabble_step(input logic [21:0] v);
    logic [21:0] s;
    s = v >> 1;
    for (int n = 0; n < 3; n++) begin
      if (s[10 + 4*n + 3]) s[10 + 4*n +: 4] = s[10 + 4*n +: 4] - 4'd3;
    end
    return s;
  endfunction

  function automatic logic digits_ok(input logic [3:0] c, input logic [3:0] d,
                                     input logic [3:0] u);
    return (c <= 4'd9) && (d <= 4'd9) && (u <= 4'd9);
  endfunction

  assign step_w = dabble_step({bcd_q, bin_q});

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    erro_d  = erro_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          if (digits_ok(bus.C, bus.D, bus.U)) begin
            bcd_d   = {bus.C, bus.D, bus.U};
            bin_d   = '0;
            cnt_d   = '0;
            erro_d  = 1'b0;
            state_d = SHIFT;
          end else begin
            erro_d = 1'b1;
            num_d  = '0;
            done_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        bcd_d = step_w[21:10];
        bin_d = step_w[9:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          num_d   = step_w[9:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      done_q  <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      done_q  <= done_d;
      erro_q  <= erro_d;
    end
  end

  assign bus.NUM  = num_q;
  assign bus.BUSY = (state_q == SHIFT);
  assign bus.DONE = done_q;
  assign bus.ERRO = erro_q;

endmodule

// File: tb/tb_conversao_bcd_binario.sv
// Randomized and directed bench for conversao_bcd_binario against an arithmetic reference.
module tb_conversao_bcd_binario;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  conversao_bcd_binario_if bus();

  conversao_bcd_binario dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_num(input int c, input int d, input int u);
    return 100*c + 10*d + u;
  endfunction

  // One request; optionally disturbs START and digits mid-conversion.
  task automatic run_req(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u,
                         input bit disturb);
    bit valid;
    int cyc;
    bit both;
    bit busy_seen;
    bit busy1;
    logic [9:0] num_at_done;
    valid = (c <= 9) && (d <= 9) && (u <= 9);
    cyc = 0; both = 0; busy_seen = 0; busy1 = 0;
    bus.START = 1'b1; bus.C = c; bus.D = d; bus.U = u;
    do begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) begin
        bus.START = 1'b0;
        busy1 = bus.BUSY;
      end
      if (bus.BUSY && bus.DONE) both = 1;
      if (bus.BUSY) busy_seen = 1;
      if (disturb && cyc == 4) begin
        bus.START = 1'b1; bus.C = 4'd9; bus.D = 4'd9; bus.U = 4'd9;
      end
      if (disturb && cyc == 5) begin
        bus.START = 1'b0; bus.C = c; bus.D = d; bus.U = u;
      end
    end while (!bus.DONE && cyc < 20);
    chk("latency", cyc, valid ? 11 : 1);
    chk("num", bus.NUM, valid ? model_num(c, d, u) : 0);
    chk("erro", bus.ERRO, valid ? 0 : 1);
    chk("busy_at_done", bus.BUSY, 0);
    chk("busy_done_overlap", both, 0);
    if (valid) chk("busy_after_start", busy1, 1);
    else       chk("busy_never_invalid", busy_seen, 0);
    num_at_done = bus.NUM;
    @(negedge CLK);
    chk("done_one_cycle", bus.DONE, 0);
    chk("num_held", bus.NUM, num_at_done);
  endtask

  initial begin
    int cyc;
    bus.START = 1'b0; bus.C = '0; bus.D = '0; bus.U = '0;

    repeat (3) @(negedge CLK);
    chk("rst_num", bus.NUM, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_done", bus.DONE, 0);
    chk("rst_erro", bus.ERRO, 0);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_done", bus.DONE, 0);

    run_req(4'd9, 4'd9, 4'd9, 0);
    run_req(4'd2, 4'd5, 4'd5, 0);
    run_req(4'd5, 4'd1, 4'd2, 0);
    run_req(4'd0, 4'd0, 4'd0, 0);
    run_req(4'hA, 4'd0, 4'd0, 0);
    run_req(4'd1, 4'd2, 4'd3, 0);
    run_req(4'd0, 4'd4, 4'd2, 1);

    // Asynchronous reset in the middle of a conversion.
    bus.START = 1'b1; bus.C = 4'd7; bus.D = 4'd7; bus.U = 4'd7;
    @(negedge CLK);
    bus.START = 1'b0;
    repeat (5) @(negedge CLK);
    chk("busy_before_rst", bus.BUSY, 1);
    #2 RST = 1'b1;
    #1;
    chk("arst_busy", bus.BUSY, 0);
    chk("arst_done", bus.DONE, 0);
    chk("arst_num", bus.NUM, 0);
    chk("arst_erro", bus.ERRO, 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("idle_after_rst", bus.BUSY, 0);
    run_req(4'd3, 4'd0, 4'd1, 0);

    // Randomized requests, occasionally with an out-of-range digit.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] r [3];
      for (int k = 0; k < 3; k++)
        r[k] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                            : 4'($urandom_range(0, 9));
      run_req(r[0], r[1], r[2], 0);
    end

    // Exhaustive sweep with START held high: one result every 11 cycles.
    bus.START = 1'b1;
    bus.C = 4'd0; bus.D = 4'd0; bus.U = 4'd0;
    for (int i = 0; i < 1000; i++) begin
      cyc = 0;
      do begin
        @(negedge CLK);
        cyc++;
      end while (!bus.DONE && cyc < 20);
      chk("sweep_spacing", cyc, 11);
      chk("sweep_num", bus.NUM, model_num(i / 100, (i / 10) % 10, i % 10));
      if (i < 999) begin
        bus.C = 4'((i + 1) / 100);
        bus.D = 4'(((i + 1) / 10) % 10);
        bus.U = 4'((i + 1) % 10);
      end
    end
    bus.START = 1'b0;
    @(negedge CLK);
    chk("sweep_end_done", bus.DONE, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
